id_branch_hazard_ctrl: RTL and testbench
========================================

Name: id_branch_hazard_ctrl

Overview:
- ID-stage hazard/stall controller that sits directly upstream of the ID forwarding unit and the branch comparator.
- Detects cases where an ID-stage operand cannot be supplied by MEM/WB forwarding:
  - load-use;
  - branch depending on an EX-stage result;
  - branch depending on an in-flight load.
- Freezes PC and IF/ID, and injects ID/EX bubbles through a small stall FSM with a down-counter.
- Issues the IF/ID flush for taken branches and keeps saturating stall/flush event counters for perf analysis.

Parameters:
- CNT_W, 32, width of the stall-cycle and branch-flush event counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_Opcode  in  7  opcode of the instruction in ID; encodings from RV32_Opcodes.vh.
- ID_rs1  in  5  ID source register 1.
- ID_rs2  in  5  ID source register 2.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_RegWrite  in  1  EX instruction writes the register file.
- EX_WBSrc  in  1  1 = EX instruction is a load (memory writeback), 0 = ALU result.
- MEM_rd  in  5  destination register of the instruction in MEM.
- MEM_RegWrite  in  1  MEM instruction writes the register file.
- MEM_WBSrc  in  1  1 = MEM instruction is a load.
- ID_BranchTaken  in  1  branch comparator result for ID, already using forwarded operands.
- PCWrite  out  1  0 = hold PC.
- IFID_Write  out  1  0 = hold IF/ID register.
- IDEX_Bubble  out  1  1 = load NOP controls into ID/EX.
- IFID_Flush  out  1  1 = squash the instruction in IF/ID at the next edge.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.
- branch_flushes  out  CNT_W  saturating count of taken-branch flushes.

Behaviour:
- Operand use:
  - rs1 is used by BRANCH, LOAD, STORE, OP, OP_IMM and JALR.
  - rs2 is used by BRANCH, STORE and OP.
  - A match requires the producer rd != 0, producer RegWrite = 1, and the source in use.
- Stall requirement N, evaluated in IDLE:
  - Branch in ID, EX match, EX_WBSrc = 0: N = 1.
  - Branch in ID, EX match, EX_WBSrc = 1: N = 2.
  - Branch in ID, MEM match, MEM_WBSrc = 1: N = 1.
  - Non-branch in ID, EX match, EX_WBSrc = 1: N = 1 (load-use).
  - Otherwise N = 0.
  - Where several conditions apply, N is the maximum.
  - MEM ALU results and WB results are covered by forwarding and never stall.
- FSM states: IDLE and STALL, plus a 2-bit counter cnt.
- IDLE:
  - If N > 0, stall this cycle (combinational outputs).
  - If N = 2, load cnt = 1 and go to STALL; otherwise stay in IDLE.
- STALL:
  - Stall unconditionally; inputs are ignored.
  - Decrement cnt; return to IDLE when cnt is 0 at the edge.
  - Re-evaluation happens in IDLE on the following cycle.
- Stall outputs: PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1; otherwise 1/1/0.
- IFID_Flush:
  - Asserted = ID_Opcode == BRANCH && ID_BranchTaken && no stall this cycle.
  - Branch resolution in a stalled cycle is invalid, so stall suppresses the flush.
- Counters:
  - stall_cycles increments on every stalled cycle.
  - branch_flushes increments on every IFID_Flush cycle.
  - Both saturate at all-ones and never wrap.
- Reset (async, any time including mid-STALL):
  - State returns to IDLE, cnt = 0, counters = 0.
  - While rst = 1 the outputs are PCWrite = 1, IFID_Write = 1, IDEX_Bubble = 0, IFID_Flush = 0.
- Latency: stall and flush decisions are combinational in the same cycle; counters update at the next edge.

Decomposition:
- The operand-use decode (uses_rs1/uses_rs2 from opcode) and the FSM state encodings belong in a shared package/header next to RV32_Opcodes.vh.
- One sub-module is natural: sat_counter (parameter CNT_W, inc input), instantiated twice.

Test Plan:
- Branch rs1 = x5 in ID, EX ALU writing x5 (EX_WBSrc = 0) -> exactly 1 stall cycle (PCWrite = 0, IDEX_Bubble = 1), then stall_cycles = 1.
- Branch rs2 = x7, EX load writing x7 -> 2 consecutive stall cycles via STALL state, stall_cycles = 2; changing inputs during the second cycle has no effect.
- ADD in ID with rs2 = x3, EX load to x3 -> 1 stall; same with EX_rd = x0 -> 0 stalls.
- Taken branch with no hazard -> IFID_Flush = 1 for one cycle, branch_flushes = 1; taken branch while stalled -> IFID_Flush = 0.
- Assert rst during the second cycle of an N = 2 stall -> outputs return immediately to 1/1/0/0, both counters = 0, and the next hazard is evaluated from IDLE.
- Force stall_cycles to its all-ones value (CNT_W = 4, value 15), then stall again -> it stays at 15.

Source files
------------

// File: rtl/id_branch_hazard_ctrl_pkg.sv
// Shared ID-stage hazard definitions: RV32 opcodes, operand-use decode,
// and stall FSM state encodings.
package id_branch_hazard_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;

   function automatic logic uses_rs1(input logic [6:0] opc);
      unique case (opc)
         OPC_BRANCH, OPC_LOAD, OPC_STORE,
         OPC_OP, OPC_OP_IMM, OPC_JALR: uses_rs1 = 1'b1;
         default:                      uses_rs1 = 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opc);
      unique case (opc)
         OPC_BRANCH, OPC_STORE, OPC_OP: uses_rs2 = 1'b1;
         default:                       uses_rs2 = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/id_branch_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/id_branch_hazard_ctrl.sv
// ID-stage hazard controller: stalls when MEM/WB forwarding cannot supply
// an operand, flushes IF/ID on taken branches, counts both events.
module id_branch_hazard_ctrl
   import id_branch_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       ID_Opcode,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic [4:0]       EX_rd,
   input  logic             EX_RegWrite,
   input  logic             EX_WBSrc,
   input  logic [4:0]       MEM_rd,
   input  logic             MEM_RegWrite,
   input  logic             MEM_WBSrc,
   input  logic             ID_BranchTaken,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IDEX_Bubble,
   output logic             IFID_Flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] branch_flushes
);

   logic [0:0] state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic       is_br, use1, use2;
   logic       ex_hit, mem_hit;
   logic       need1, need2;
   logic       stall, stall_out;

   always_comb begin
      is_br   = (ID_Opcode == OPC_BRANCH);
      use1    = uses_rs1(ID_Opcode);
      use2    = uses_rs2(ID_Opcode);
      ex_hit  = EX_RegWrite && (EX_rd != 5'd0) &&
                ((use1 && (ID_rs1 == EX_rd)) ||
                 (use2 && (ID_rs2 == EX_rd)));
      mem_hit = MEM_RegWrite && (MEM_rd != 5'd0) &&
                ((use1 && (ID_rs1 == MEM_rd)) ||
                 (use2 && (ID_rs2 == MEM_rd)));
      // A branch behind an EX load needs the load through MEM first.
      need2   = is_br && ex_hit && EX_WBSrc;
      need1   = (is_br && ex_hit) ||
                (is_br && mem_hit && MEM_WBSrc) ||
                (!is_br && ex_hit && EX_WBSrc);
   end

   assign stall = (state == ST_STALL) || need1 || need2;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == ST_IDLE) begin
         if (need2) begin
            state_nxt = ST_STALL;
            cnt_nxt   = 2'd1;
         end
      end else begin
         cnt_nxt = cnt - 2'd1;
         if (cnt_nxt == 2'd0) begin
            state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Reset forces the pipeline-free values regardless of FSM state.
   assign stall_out   = stall && !rst;
   assign PCWrite     = !stall_out;
   assign IFID_Write  = !stall_out;
   assign IDEX_Bubble = stall_out;
   assign IFID_Flush  = !rst && is_br && ID_BranchTaken && !stall;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_out),
      .count (stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (IFID_Flush),
      .count (branch_flushes)
   );

endmodule

// File: tb/tb_id_branch_hazard_ctrl.sv
// Scoreboard bench for id_branch_hazard_ctrl: driver pushes model
// expectations, a monitor pops and compares every cycle.
module tb_id_branch_hazard_ctrl;

   localparam int W    = 4;
   localparam int MAXC = 15;

   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] LD   = 7'b0000011;
   localparam logic [6:0] ST   = 7'b0100011;
   localparam logic [6:0] OPR  = 7'b0110011;
   localparam logic [6:0] OPI  = 7'b0010011;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] LUI  = 7'b0110111;

   logic         clk;
   logic         rst;
   logic [6:0]   ID_Opcode;
   logic [4:0]   ID_rs1, ID_rs2, EX_rd, MEM_rd;
   logic         EX_RegWrite, EX_WBSrc, MEM_RegWrite, MEM_WBSrc;
   logic         ID_BranchTaken;
   logic         PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush;
   logic [W-1:0] stall_cycles, branch_flushes;

   typedef struct {
      logic         pc;
      logic         ifw;
      logic         bub;
      logic         fl;
      logic [W-1:0] sc;
      logic [W-1:0] bf;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;
   int   remaining = 0;
   int   m_sc = 0;
   int   m_bf = 0;

   id_branch_hazard_ctrl #(.CNT_W(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .ID_Opcode      (ID_Opcode),
      .ID_rs1         (ID_rs1),
      .ID_rs2         (ID_rs2),
      .EX_rd          (EX_rd),
      .EX_RegWrite    (EX_RegWrite),
      .EX_WBSrc       (EX_WBSrc),
      .MEM_rd         (MEM_rd),
      .MEM_RegWrite   (MEM_RegWrite),
      .MEM_WBSrc      (MEM_WBSrc),
      .ID_BranchTaken (ID_BranchTaken),
      .PCWrite        (PCWrite),
      .IFID_Write     (IFID_Write),
      .IDEX_Bubble    (IDEX_Bubble),
      .IFID_Flush     (IFID_Flush),
      .stall_cycles   (stall_cycles),
      .branch_flushes (branch_flushes)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, required %0h", nm, act, req);
   endtask

   // Stall cycles required by the instruction currently in ID.
   function automatic int need(input logic [6:0] op,
                               input logic [4:0] r1, r2, erd,
                               input logic erw, ewb,
                               input logic [4:0] mrd,
                               input logic mrw, mwb);
      bit u1, u2, exm, memm, br;
      int n;
      br   = (op == BR);
      u1   = op inside {BR, LD, ST, OPR, OPI, JALR};
      u2   = op inside {BR, ST, OPR};
      exm  = erw && erd != 0 && ((u1 && r1 == erd) || (u2 && r2 == erd));
      memm = mrw && mrd != 0 && ((u1 && r1 == mrd) || (u2 && r2 == mrd));
      n = 0;
      if (br && exm) n = ewb ? 2 : 1;
      if (br && memm && mwb && n < 1) n = 1;
      if (!br && exm && ewb && n < 1) n = 1;
      return n;
   endfunction

   task automatic drive(input logic [6:0] op, input logic [4:0] r1, r2,
                        input logic [4:0] erd, input logic erw, ewb,
                        input logic [4:0] mrd, input logic mrw, mwb,
                        input logic tk, input logic rs);
      exp_t e;
      bit   st;
      int   n;
      @(posedge clk);
      #1;
      ID_Opcode = op; ID_rs1 = r1; ID_rs2 = r2;
      EX_rd = erd; EX_RegWrite = erw; EX_WBSrc = ewb;
      MEM_rd = mrd; MEM_RegWrite = mrw; MEM_WBSrc = mwb;
      ID_BranchTaken = tk; rst = rs;
      if (rs) begin
         remaining = 0; m_sc = 0; m_bf = 0;
         e.pc = 1; e.ifw = 1; e.bub = 0; e.fl = 0; e.sc = 0; e.bf = 0;
      end else begin
         e.sc = W'(m_sc);
         e.bf = W'(m_bf);
         if (remaining > 0) begin
            st = 1;
            remaining--;
         end else begin
            n = need(op, r1, r2, erd, erw, ewb, mrd, mrw, mwb);
            st = (n > 0);
            remaining = st ? n - 1 : 0;
         end
         e.pc = !st; e.ifw = !st; e.bub = st;
         e.fl = (op == BR) && tk && !st;
         if (st && m_sc < MAXC) m_sc++;
         if (e.fl && m_bf < MAXC) m_bf++;
      end
      q.push_back(e);
   endtask

   task automatic nop();
      drive(OPR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Monitor: outputs are valid every cycle; sampled mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pcwrite", 32'(PCWrite), 32'(e.pc));
            chk("ifid_write", 32'(IFID_Write), 32'(e.ifw));
            chk("idex_bubble", 32'(IDEX_Bubble), 32'(e.bub));
            chk("ifid_flush", 32'(IFID_Flush), 32'(e.fl));
            chk("stall_cycles", 32'(stall_cycles), 32'(e.sc));
            chk("branch_flushes", 32'(branch_flushes), 32'(e.bf));
         end
      end
   end

   initial begin
      logic [6:0] ops [8];
      ops = '{BR, LD, ST, OPR, OPI, JALR, JAL, LUI};
      rst = 1'b1;
      ID_Opcode = OPR; ID_rs1 = 0; ID_rs2 = 0;
      EX_rd = 0; EX_RegWrite = 0; EX_WBSrc = 0;
      MEM_rd = 0; MEM_RegWrite = 0; MEM_WBSrc = 0;
      ID_BranchTaken = 0;

      drive(OPR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(OPR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      settle();
      chk("reset_stall_cycles", 32'(stall_cycles), 0);

      // Branch on EX ALU result: one stall
      drive(BR, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0);
      settle();
      chk("br_ex_alu_pcwrite", 32'(PCWrite), 0);
      nop();
      settle();
      chk("br_ex_alu_count", 32'(stall_cycles), 1);
      chk("br_ex_alu_release", 32'(PCWrite), 1);

      // Branch on EX load: two stalls, second ignores inputs
      drive(BR, 1, 7, 7, 1, 1, 0, 0, 0, 1, 0);
      drive(OPR, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      settle();
      chk("br_ex_ld_2nd_bubble", 32'(IDEX_Bubble), 1);
      nop();
      settle();
      chk("br_ex_ld_count", 32'(stall_cycles), 3);

      // Load-use on rs2, then the same with x0
      drive(OPR, 1, 3, 3, 1, 1, 0, 0, 0, 0, 0);
      drive(OPR, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      settle();
      chk("x0_no_stall", 32'(PCWrite), 1);

      // Branch on MEM load: one stall; MEM ALU: none
      drive(BR, 9, 2, 0, 0, 0, 9, 1, 1, 0, 0);
      drive(BR, 9, 2, 0, 0, 0, 9, 1, 0, 0, 0);

      // Taken branch flush, and suppressed flush while stalled
      drive(BR, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
      settle();
      chk("taken_flush", 32'(IFID_Flush), 1);
      drive(BR, 4, 2, 4, 1, 0, 0, 0, 0, 1, 0);
      settle();
      chk("stalled_no_flush", 32'(IFID_Flush), 0);
      chk("flush_count", 32'(branch_flushes), 1);
      nop();

      // Reset during the second cycle of a two-cycle stall
      drive(BR, 6, 0, 6, 1, 1, 0, 0, 0, 0, 0);
      drive(BR, 6, 0, 6, 1, 1, 0, 0, 0, 1, 1);
      settle();
      chk("rst_mid_pcwrite", 32'(PCWrite), 1);
      chk("rst_mid_count", 32'(stall_cycles), 0);
      drive(BR, 2, 0, 2, 1, 0, 0, 0, 0, 0, 0);
      nop();
      settle();
      chk("post_rst_idle", 32'(PCWrite), 1);
      chk("post_rst_count", 32'(stall_cycles), 1);

      // Saturation of both counters
      for (int i = 0; i < 18; i++) drive(LD, 8, 0, 8, 1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 18; i++) drive(BR, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      settle();
      chk("sat_stall", 32'(stall_cycles), 15);
      chk("sat_flush", 32'(branch_flushes), 15);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         drive(ops[$urandom_range(0, 7)],
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               1'($urandom), ($urandom_range(0, 24) == 0));
      end

      @(posedge clk);
      settle();
      checks++;
      if (q.size() == 0) passes++;
      else $display("FAIL scoreboard_drain: got %0d left, required 0",
                    q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
